// File: rtl/ltpi_csr_avmm_timeout_bridge.sv
// ltpi_csr_avmm_timeout_bridge
//   Single-outstanding Avalon-MM bridge from the management host to the LTPI
//   CSR slave. The host command is registered and forwarded. A watchdog
//   aborts any forwarded command that makes no progress within TIMEOUT_CYCLES.
//   When that happens, a read returns TIMEOUT_RDATA and a write is dropped.
//   Each timeout sets a sticky flag and bumps a saturating 8-bit counter.
//
// Ports
//   clk, reset         single clock, synchronous active-high reset
//   avs_*              host-side slave (address/read/write/writedata/
//                      byteenable in; waitrequest/readdata/readdatavalid out)
//   avm_*              CSR-side master (address/read/write/writedata/
//                      byteenable out; waitrequest/readdata/readdatavalid in)
//   timeout_clr        clears timeout_flag / timeout_cnt
//   timeout_flag       sticky timeout indication
//   timeout_cnt        saturating timeout count
module ltpi_csr_avmm_timeout_bridge #(
    parameter int                ADDR_W         = 16,
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [DATA_W-1:0]   avs_writedata,
    input  logic [DATA_W/8-1:0] avs_byteenable,
    output logic                avs_waitrequest,
    output logic [DATA_W-1:0]   avs_readdata,
    output logic                avs_readdatavalid,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid,
    input  logic                timeout_clr,
    output logic                timeout_flag,
    output logic [7:0]          timeout_cnt
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CMD, RDATA, RESP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             is_write;
    logic             cap_cmd;
    logic             cap_rdata;
    logic             to_fire;
    logic             cnt_last;

    assign cnt_last = (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        cap_cmd   = 1'b0;
        cap_rdata = 1'b0;
        to_fire   = 1'b0;
        case (state)
            IDLE: begin
                // A late readdatavalid from a timed-out read lands here and is dropped.
                if (avs_write || avs_read) begin
                    cap_cmd   = 1'b1;
                    state_nxt = CMD;
                end
            end
            CMD: begin
                // Progress in the final cycle beats the timeout.
                if (!avm_waitrequest) begin
                    if (is_write) begin
                        state_nxt = IDLE;
                    end else if (avm_readdatavalid) begin
                        cap_rdata = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = RDATA;
                    end
                end else if (cnt_last) begin
                    to_fire   = 1'b1;
                    state_nxt = is_write ? IDLE : RESP;
                end
            end
            RDATA: begin
                if (avm_readdatavalid) begin
                    cap_rdata = 1'b1;
                    state_nxt = RESP;
                end else if (cnt_last) begin
                    to_fire   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign avs_waitrequest   = (state != IDLE);
    assign avs_readdatavalid = (state == RESP);
    assign avm_read          = (state == CMD) && !is_write;
    assign avm_write         = (state == CMD) && is_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            is_write       <= 1'b0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            avs_readdata   <= '0;
            timeout_flag   <= 1'b0;
            timeout_cnt    <= 8'd0;
        end else begin
            state <= state_nxt;

            // Write wins when read and write arrive together.
            if (cap_cmd) begin
                avm_address    <= avs_address;
                avm_writedata  <= avs_writedata;
                avm_byteenable <= avs_byteenable;
                is_write       <= avs_write;
                cnt            <= '0;
            end else if ((state == CMD || state == RDATA) && !cnt_last) begin
                // The counter holds at its last value. A read accepted in
                // that final cycle then times out on its first RDATA cycle
                // if no readdatavalid has arrived.
                cnt <= cnt + 1'b1;
            end

            if (cap_rdata)
                avs_readdata <= avm_readdata;
            else if (to_fire && !is_write)
                avs_readdata <= TIMEOUT_RDATA;

            if (to_fire) begin
                timeout_flag <= 1'b1;
                timeout_cnt  <= timeout_clr ? 8'd1
                              : (timeout_cnt == 8'hFF) ? timeout_cnt
                              : timeout_cnt + 8'd1;
            end else if (timeout_clr) begin
                timeout_flag <= 1'b0;
                timeout_cnt  <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_ltpi_csr_avmm_timeout_bridge.sv
// Directed bench for ltpi_csr_avmm_timeout_bridge (TIMEOUT_CYCLES = 16).
// A transaction-level model predicts every output on every cycle. Literal
// checks at key cycles pin the model to hand-computed values.
module tb_ltpi_csr_avmm_timeout_bridge;

    localparam int          TC   = 16;
    localparam logic [31:0] TORD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [15:0] avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        timeout_clr;
    logic        timeout_flag;
    logic [7:0]  timeout_cnt;

    ltpi_csr_avmm_timeout_bridge #(
        .ADDR_W(16), .DATA_W(32), .TIMEOUT_CYCLES(TC), .TIMEOUT_RDATA(TORD)
    ) dut (
        .clk(clk), .reset(reset),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .timeout_clr(timeout_clr), .timeout_flag(timeout_flag),
        .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // One in-flight transaction record, aged in cycles since the host accept
    // edge. Timeout happens when the age reaches TC without progress.
    bit          m_busy, m_acc, m_write, m_resp, m_to, m_flag;
    int          m_age, m_cnt;
    logic [15:0] m_addr;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_be;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_acc = 0; m_write = 0; m_resp = 0; m_flag = 0;
            m_cnt = 0; m_age = 0; m_addr = '0; m_wdata = '0; m_be = '0; m_rdata = '0;
        end else begin
            m_to = 0;
            if (m_resp) begin
                m_resp = 0;
            end else if (!m_busy) begin
                if (avs_write || avs_read) begin
                    m_busy = 1; m_acc = 0; m_age = 0; m_write = avs_write;
                    m_addr = avs_address; m_wdata = avs_writedata; m_be = avs_byteenable;
                end
            end else begin
                m_age++;
                if (!m_acc && !avm_waitrequest) begin
                    if (m_write) m_busy = 0;
                    else if (avm_readdatavalid) begin
                        m_busy = 0; m_resp = 1; m_rdata = avm_readdata;
                    end else m_acc = 1;
                end else if (m_acc && avm_readdatavalid) begin
                    m_busy = 0; m_resp = 1; m_rdata = avm_readdata;
                end else if (m_age >= TC) begin
                    m_to = 1; m_busy = 0;
                    if (!m_write) begin m_resp = 1; m_rdata = TORD; end
                end
            end
            if (m_to) begin
                m_flag = 1;
                m_cnt  = timeout_clr ? 1 : (m_cnt >= 255 ? 255 : m_cnt + 1);
            end else if (timeout_clr) begin
                m_flag = 0; m_cnt = 0;
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("waitrequest", avs_waitrequest, m_busy || m_resp);
            chk("readdatavalid", avs_readdatavalid, m_resp);
            chk("readdata", avs_readdata, m_rdata);
            chk("avm_read", avm_read, m_busy && !m_acc && !m_write);
            chk("avm_write", avm_write, m_busy && !m_acc && m_write);
            chk("avm_address", avm_address, m_addr);
            chk("avm_writedata", avm_writedata, m_wdata);
            chk("avm_byteenable", avm_byteenable, m_be);
            chk("timeout_flag", timeout_flag, m_flag);
            chk("timeout_cnt", timeout_cnt, m_cnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic host_cmd(input bit rd, input bit wr, input logic [15:0] a, input logic [31:0] d);
        avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = d; avs_byteenable = 4'hF;
        tick();
        avs_read = 0; avs_write = 0;
    endtask

    initial begin
        reset = 1; avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
        avs_byteenable = '0; avm_waitrequest = 0; avm_readdata = '0;
        avm_readdatavalid = 0; timeout_clr = 0;
        tick();
        chk_en = 1;
        tick(); tick();
        @(negedge clk);
        chk("lit reset waitrequest", avs_waitrequest, 0);
        chk("lit reset avm_read", avm_read, 0);
        reset = 0;
        tick();

        // 1: zero-wait write
        host_cmd(0, 1, 16'h0010, 32'h1234_5678);
        @(negedge clk);
        chk("lit wr avm_write T+1", avm_write, 1);
        chk("lit wr avm_address", avm_address, 16'h0010);
        chk("lit wr avm_writedata", avm_writedata, 32'h1234_5678);
        tick();
        @(negedge clk);
        chk("lit wr waitrequest T+2", avs_waitrequest, 0);
        chk("lit wr flag", timeout_flag, 0);

        // 2: read, 3 stall cycles, data two cycles after accept
        avm_waitrequest = 1;
        host_cmd(1, 0, 16'h0004, '0);
        tick(); tick(); tick();
        avm_waitrequest = 0;
        tick();
        tick();
        avm_readdatavalid = 1; avm_readdata = 32'hA5A5_0001;
        tick();
        avm_readdatavalid = 0;
        @(negedge clk);
        chk("lit rd readdatavalid", avs_readdatavalid, 1);
        chk("lit rd readdata", avs_readdata, 32'hA5A5_0001);
        tick();
        @(negedge clk);
        chk("lit rd rdv one cycle", avs_readdatavalid, 0);

        // 3: read timeout, then a late response that must be ignored
        avm_waitrequest = 1;
        host_cmd(1, 0, 16'h0008, '0);
        repeat (TC) tick();
        @(negedge clk);
        chk("lit to rdv T+17", avs_readdatavalid, 1);
        chk("lit to readdata", avs_readdata, TORD);
        chk("lit to avm_read", avm_read, 0);
        chk("lit to flag", timeout_flag, 1);
        chk("lit to cnt", timeout_cnt, 1);
        tick();
        avm_readdatavalid = 1; avm_readdata = 32'h1111_1111;
        tick();
        avm_readdatavalid = 0;
        @(negedge clk);
        chk("lit late rdv ignored", avs_readdatavalid, 0);
        chk("lit late readdata held", avs_readdata, TORD);

        // 4: read accepted in the last cycle before timeout
        host_cmd(1, 0, 16'h000C, '0);
        repeat (TC - 1) tick();
        avm_waitrequest = 0; avm_readdatavalid = 1; avm_readdata = 32'h600D_0015;
        tick();
        avm_readdatavalid = 0;
        @(negedge clk);
        chk("lit edge rdv", avs_readdatavalid, 1);
        chk("lit edge readdata", avs_readdata, 32'h600D_0015);
        chk("lit edge cnt", timeout_cnt, 1);
        tick();

        // 5: 257 write timeouts saturate the counter, then clear behaviour
        avm_waitrequest = 1;
        for (int i = 0; i < 257; i++) begin
            host_cmd(0, 1, 16'h0100, i);
            repeat (TC) tick();
        end
        @(negedge clk);
        chk("lit sat cnt", timeout_cnt, 255);
        timeout_clr = 1;
        tick();
        timeout_clr = 0;
        @(negedge clk);
        chk("lit clr flag", timeout_flag, 0);
        chk("lit clr cnt", timeout_cnt, 0);
        host_cmd(0, 1, 16'h0104, 32'h0);
        repeat (TC - 1) tick();
        timeout_clr = 1;
        tick();
        timeout_clr = 0;
        @(negedge clk);
        chk("lit clr+to flag", timeout_flag, 1);
        chk("lit clr+to cnt", timeout_cnt, 1);
        avm_waitrequest = 0;
        tick();

        // 6: read and write together -> write only
        host_cmd(1, 1, 16'h0020, 32'hCAFE_0000);
        @(negedge clk);
        chk("lit both avm_write", avm_write, 1);
        chk("lit both avm_read", avm_read, 0);
        repeat (3) tick();

        // reset in the middle of RDATA
        host_cmd(1, 0, 16'h0030, '0);
        tick();
        reset = 1;
        tick();
        @(negedge clk);
        chk("lit rst waitrequest", avs_waitrequest, 0);
        chk("lit rst avm_address", avm_address, 0);
        chk("lit rst readdata", avs_readdata, 0);
        reset = 0;
        tick();
        avm_readdatavalid = 1; avm_readdata = 32'h0BAD_F00D;
        host_cmd(1, 0, 16'h0034, '0);
        tick();
        avm_readdatavalid = 0;
        @(negedge clk);
        chk("lit post-rst rdv", avs_readdatavalid, 1);
        chk("lit post-rst readdata", avs_readdata, 32'h0BAD_F00D);
        repeat (3) tick();

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ltpi_csr_avmm_timeout_bridge.md
Name: ltpi_csr_avmm_timeout_bridge

Overview:
- Single-outstanding Avalon-MM bridge between the management host (BMC/SCM CPU interface) and the LTPI CSR AVMM slave.
- Registers each host command and forwards it to the CSR slave.
- Enforces a transaction timeout so a hung or unmapped CSR access can never stall the host bus.
- Reports timeouts via a sticky flag and a saturating counter.

Parameters:
- ADDR_W, 16, address width on both sides
- DATA_W, 32, data width; byteenable width is DATA_W/8
- TIMEOUT_CYCLES, 1024, maximum cycles from forward-command issue to completion; minimum legal value 2
- TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned on a read timeout

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- avs_address  in  ADDR_W  host address
- avs_read  in  1  host read request
- avs_write  in  1  host write request
- avs_writedata  in  DATA_W  host write data
- avs_byteenable  in  DATA_W/8  host byte enables
- avs_waitrequest  out  1  host stall
- avs_readdata  out  DATA_W  read response data
- avs_readdatavalid  out  1  read response strobe
- avm_address  out  ADDR_W  address to CSR slave
- avm_read  out  1  read to CSR slave
- avm_write  out  1  write to CSR slave
- avm_writedata  out  DATA_W  write data to CSR slave
- avm_byteenable  out  DATA_W/8  byte enables to CSR slave
- avm_waitrequest  in  1  CSR slave stall
- avm_readdata  in  DATA_W  CSR slave read data
- avm_readdatavalid  in  1  CSR slave read data strobe
- timeout_clr  in  1  clears timeout_flag and timeout_cnt
- timeout_flag  out  1  sticky timeout indication
- timeout_cnt  out  8  saturating timeout count

Behaviour:

Reset values:
- All outputs 0 on reset, except avs_waitrequest = 0.
- State = IDLE, internal counter = 0.
- Reset mid-transaction aborts it with no host response.

FSM states are IDLE, CMD, RDATA and RESP.

IDLE:
- avs_waitrequest = 0.
- On avs_write or avs_read, capture address, writedata, byteenable and direction, then go to CMD.
- If avs_read and avs_write are both high, the write wins and the read is dropped, with no readdatavalid.
- avm_readdatavalid arriving in IDLE (late response) is ignored.

CMD:
- avs_waitrequest = 1.
- avm_read or avm_write is held with the registered fields until a cycle with avm_waitrequest = 0.
- On acceptance of a write, go to IDLE.
- On acceptance of a read with avm_readdatavalid low, go to RDATA.
- On acceptance of a read with avm_readdatavalid in the same cycle, capture avm_readdata and go to RESP.

RDATA:
- avs_waitrequest = 1, avm_read = 0.
- On avm_readdatavalid, capture avm_readdata and go to RESP.

RESP:
- avs_readdatavalid = 1 and avs_readdata = captured data for exactly one cycle, then go to IDLE.
- avs_waitrequest = 1 in this state.
- avs_readdata holds its value outside RESP.

Latency (host accept edge = T):
- avm_* command asserted from T+1.
- Zero-wait write: back in IDLE at T+2.
- Zero-wait read with same-cycle readdatavalid: avs_readdatavalid at T+2.

Timeout:
- Counter cleared on entry to CMD.
- Increments every cycle in CMD or RDATA, and is not cleared on CMD→RDATA.
- A timeout fires in a cycle where the counter = TIMEOUT_CYCLES-1 and the cycle's progress event is absent (acceptance in CMD, readdatavalid in RDATA).
- If progress occurs in that same cycle, progress wins and there is no timeout.
- On timeout:
  - Deassert avm_read/avm_write on the next cycle.
  - A read goes to RESP with TIMEOUT_RDATA.
  - A write goes to IDLE.
  - Set timeout_flag.
  - Increment timeout_cnt, saturating at 255.
- Resulting timing: avm_* is high for at most TIMEOUT_CYCLES cycles (T+1..T+TIMEOUT_CYCLES), and a timed-out read gives avs_readdatavalid at T+TIMEOUT_CYCLES+1.

timeout_clr:
- Clears timeout_flag and timeout_cnt on the next edge.
- If a timeout occurs in the same cycle, the timeout wins: flag = 1, cnt = 1.

Test Plan:
- TIMEOUT_CYCLES=16. Host write addr 0x0010, data 0x1234_5678, be 0xF, slave waitrequest low → avm_write=1 at T+1 with same fields, avs_waitrequest low again at T+2, timeout_flag=0.
- Host read 0x0004, slave stalls 3 cycles, then readdatavalid 2 cycles after accept with 0xA5A5_0001 → avs_readdatavalid one cycle with 0xA5A5_0001, avs_waitrequest=1 throughout.
- Host read, slave holds waitrequest high → avm_read high 16 cycles, avs_readdatavalid at T+17 with 0xDEAD_BEEF, timeout_flag=1, timeout_cnt=1; a late avm_readdatavalid afterwards is ignored.
- Slave accepts read exactly in the cycle the counter = 15 → real data returned, no timeout, counter unchanged.
- 257 write timeouts → timeout_cnt=255. Then timeout_clr with no timeout → flag=0, cnt=0. Then timeout_clr coincident with a timeout → flag=1, cnt=1.
- avs_read and avs_write both high → only avm_write issued, no avs_readdatavalid. Reset asserted mid-RDATA → all outputs 0 next cycle and the next host read completes normally.
